// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the SRAM-like port arbiter: FSM states, owner ids, access sizes.
// Pure declarations, no timing; no flow control.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic size_legal(input logic [1:0] sz);
        return (sz == SIZE_BYTE) || (sz == SIZE_HALF) || (sz == SIZE_WORD);
    endfunction

endpackage

// File: rtl/sram_like_arbiter_prio_pick.sv
// Priority pick between fetch and data requests: data first unless fetch is starved.
// Purely combinational, zero latency; no flow control of its own.
module sram_like_arbiter_prio_pick
    import sram_like_arbiter_pkg::*;
(
    input  logic   i_inst_req,
    input  logic   i_data_req,
    input  logic   i_starve,
    output owner_t o_grant
);

    always_comb begin
        o_grant = OWN_NONE;
        if (i_inst_req && (i_starve || !i_data_req)) begin
            o_grant = OWN_INST;
        end else if (i_data_req) begin
            o_grant = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master port between fetch and data; one transaction in flight.
// Grant is combinational in IDLE (m_req same cycle); owner locked until m_data_ok.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t         r_state;
    owner_t             r_owner;
    logic [CNT_W-1:0]   r_starve_cnt;

    owner_t             w_grant;
    owner_t             w_owner;
    logic               w_starve;
    logic               w_req;
    logic               w_wr;
    logic [1:0]         w_size;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_starve = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    sram_like_arbiter_prio_pick u_pick (
        .i_inst_req (inst_req),
        .i_data_req (data_req),
        .i_starve   (w_starve),
        .o_grant    (w_grant)
    );

    // Live grant in IDLE, frozen owner once the transaction has started.
    assign w_owner = (r_state == ARB_IDLE) ? w_grant : r_owner;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant != OWN_NONE) begin
                        r_owner <= w_grant;
                        r_state <= m_addr_ok ? ARB_DATA : ARB_ADDR;
                        if (w_grant == OWN_DATA && inst_req) begin
                            if (!w_starve) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end
                end
                ARB_ADDR: begin
                    if (m_addr_ok) begin
                        r_state <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_data_ok) begin
                        r_state <= ARB_IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    always_comb begin
        w_wr    = 1'b0;
        w_size  = '0;
        w_addr  = '0;
        w_wdata = '0;
        case (w_owner)
            OWN_INST: begin
                w_size = SIZE_WORD;
                w_addr = inst_addr;
            end
            OWN_DATA: begin
                w_wr    = data_wr;
                w_size  = data_size;
                w_addr  = data_addr;
                w_wdata = data_wdata;
            end
            default: ;
        endcase
        w_req = (r_state != ARB_DATA) && (w_owner != OWN_NONE);
    end

    // Everything is gated by reset so outputs are 0 while cpu_rst_n is low.
    assign m_req        = cpu_rst_n & w_req;
    assign m_wr         = cpu_rst_n & w_wr;
    assign m_size       = cpu_rst_n ? w_size  : '0;
    assign m_addr       = cpu_rst_n ? w_addr  : '0;
    assign m_wdata      = cpu_rst_n ? w_wdata : '0;
    assign inst_addr_ok = m_req && (w_owner == OWN_INST) && m_addr_ok;
    assign data_addr_ok = m_req && (w_owner == OWN_DATA) && m_addr_ok;
    assign inst_data_ok = cpu_rst_n && (r_state == ARB_DATA) && (r_owner == OWN_INST) && m_data_ok;
    assign data_data_ok = cpu_rst_n && (r_state == ARB_DATA) && (r_owner == OWN_DATA) && m_data_ok;
    assign inst_rdata   = cpu_rst_n ? m_rdata : '0;
    assign data_rdata   = cpu_rst_n ? m_rdata : '0;

    a_inst_hold: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        (r_state == ARB_ADDR && r_owner == OWN_INST) |-> inst_req);
    a_data_hold: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        (r_state == ARB_ADDR && r_owner == OWN_DATA) |-> data_req);
    a_data_size: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        data_req |-> size_legal(data_size));

endmodule
